bomb_map: RTL and testbench

- Authoritative store of bomb positions on the 16x16 playfield; sits directly upstream of the bomb-drawing stage.
- Answers that stage's per-pixel cell-address lookups with a 1-bit "bomb present" flag at fixed 1-cycle latency.
- Accepts bomb-placement requests from game logic over a four-phase handshake.
- Runs per-bomb fuse timers on frame ticks and reports explosions one at a time.

---
 rtl/bomb_map_pkg.sv | 18 +
 rtl/bomb_map_slot.sv | 51 +++++
 rtl/bomb_map.sv | 191 +++++++++++++++++++
 tb/tb_bomb_map.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_map_pkg.sv
// Shared definitions for the bomb map block: playfield geometry constants
// and the placement handshake FSM state type.
package bomb_map_pkg;

    localparam int GRID_CELLS  = 16;
    localparam int CELL_SHIFT  = 6;
    localparam int MAP_X0      = 448;
    localparam int MAP_Y0      = 28;
    localparam int CELL_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE,
        RESP
    } place_state_t;

endpackage

// File: rtl/bomb_map_slot.sv
// One live-bomb slot: valid flag, cell address, fuse counter, pending flag.
// Ports:
//   clk, rst   pixel clock, async active-high reset
//   load       commit a new bomb at load_addr with a full fuse
//   load_addr  {y,x} of the bomb being committed
//   tick       frame tick; decrements the fuse of a live, non-pending bomb
//   clear      retire the bomb (served explosion); wins over everything
//   valid      slot holds a live bomb
//   addr       {y,x} of the bomb
//   pending    fuse has run out, explosion not yet served
module bomb_slot
    import bomb_map_pkg::*;
#(
    parameter int FUSE_FRAMES = 180
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [CELL_ADDR_W-1:0] load_addr,
    input  logic                   tick,
    input  logic                   clear,
    output logic                   valid,
    output logic [CELL_ADDR_W-1:0] addr,
    output logic                   pending
);

    logic [7:0] fuse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            addr    <= '0;
            fuse    <= '0;
            pending <= 1'b0;
        end else if (clear) begin
            valid   <= 1'b0;
            pending <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            addr    <= load_addr;
            fuse    <= 8'(FUSE_FRAMES);
            pending <= 1'b0;
        end else if (tick && valid && !pending) begin
            fuse <= fuse - 8'd1;
            if (fuse == 8'd1) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bomb_map.sv
// Bomb position store for the 16x16 playfield.
// Ports:
//   i_pclk, i_rst      pixel clock, async active-high reset
//   i_vsync            frame tick source (rising edge)
//   i_addr / o_data    1-cycle registered lookup of map[{y,x}]
//   i_place_req/x/y    four-phase placement request
//   o_place_ack/nack   placement result, held until request falls
//   o_explode/_addr    one pulse per expiring bomb, lowest slot first
//   o_bomb_count       number of live bombs
module bomb_map
    import bomb_map_pkg::*;
#(
    parameter int MAX_BOMBS   = 4,
    parameter int FUSE_FRAMES = 180
) (
    input  logic                   i_pclk,
    input  logic                   i_rst,
    input  logic                   i_vsync,
    input  logic [CELL_ADDR_W-1:0] i_addr,
    output logic                   o_data,
    input  logic                   i_place_req,
    input  logic [3:0]             i_place_x,
    input  logic [3:0]             i_place_y,
    output logic                   o_place_ack,
    output logic                   o_place_nack,
    output logic                   o_explode,
    output logic [CELL_ADDR_W-1:0] o_explode_addr,
    output logic [3:0]             o_bomb_count
);

    localparam int IDX_W = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;

    logic [GRID_CELLS*GRID_CELLS-1:0] map;
    logic                             vsync_q;
    logic                             tick;

    logic [MAX_BOMBS-1:0]   slot_valid, slot_pending, slot_load, slot_clear;
    logic [CELL_ADDR_W-1:0] slot_addr [MAX_BOMBS];

    logic                   serve_any;
    logic [IDX_W-1:0]       serve_idx;
    logic                   stall;
    logic                   commit;

    place_state_t           state, state_d;
    logic [CELL_ADDR_W-1:0] req_addr, req_addr_d;
    logic [IDX_W-1:0]       idx, idx_d, free_idx, free_idx_d;
    logic                   dup, dup_d, free_found, free_found_d;
    logic                   ack_d, nack_d;

    // vsync_q resets high so a vsync already high at release is not a tick.
    assign tick = i_vsync & ~vsync_q;

    for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
        bomb_slot #(.FUSE_FRAMES(FUSE_FRAMES)) u_slot (
            .clk      (i_pclk),
            .rst      (i_rst),
            .load     (slot_load[g]),
            .load_addr(req_addr),
            .tick     (tick),
            .clear    (slot_clear[g]),
            .valid    (slot_valid[g]),
            .addr     (slot_addr[g]),
            .pending  (slot_pending[g])
        );
    end

    // Serve arbiter: lowest pending slot first, one per cycle.
    always_comb begin
        serve_any  = 1'b0;
        serve_idx  = '0;
        slot_clear = '0;
        for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
            if (slot_pending[i] && !serve_any) begin
                serve_any = 1'b1;
                serve_idx = IDX_W'(i);
            end
        end
        if (serve_any) begin
            slot_clear[serve_idx] = 1'b1;
        end
    end

    // Ticks and serves freeze the FSM, so a commit never races a slot update.
    assign stall = tick | serve_any;

    always_comb begin
        state_d      = state;
        req_addr_d   = req_addr;
        idx_d        = idx;
        dup_d        = dup;
        free_found_d = free_found;
        free_idx_d   = free_idx;
        ack_d        = o_place_ack;
        nack_d       = o_place_nack;
        commit       = 1'b0;
        slot_load    = '0;
        if (!stall) begin
            case (state)
                IDLE: begin
                    if (i_place_req && !o_place_ack && !o_place_nack) begin
                        state_d      = SCAN;
                        req_addr_d   = {i_place_y, i_place_x};
                        idx_d        = '0;
                        dup_d        = 1'b0;
                        free_found_d = 1'b0;
                        free_idx_d   = '0;
                    end
                end
                SCAN: begin
                    if (!slot_valid[idx] && !free_found) begin
                        free_found_d = 1'b1;
                        free_idx_d   = idx;
                    end
                    if (slot_valid[idx] && slot_addr[idx] == req_addr) begin
                        dup_d = 1'b1;
                    end
                    if (idx == IDX_W'(MAX_BOMBS - 1)) begin
                        state_d = DECIDE;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
                DECIDE: begin
                    if (dup || !free_found) begin
                        nack_d = 1'b1;
                    end else begin
                        commit = 1'b1;
                        ack_d  = 1'b1;
                        slot_load[free_idx] = 1'b1;
                    end
                    state_d = RESP;
                end
                RESP: begin
                    if (!i_place_req) begin
                        ack_d   = 1'b0;
                        nack_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            req_addr     <= '0;
            idx          <= '0;
            dup          <= 1'b0;
            free_found   <= 1'b0;
            free_idx     <= '0;
            o_place_ack  <= 1'b0;
            o_place_nack <= 1'b0;
        end else begin
            state        <= state_d;
            req_addr     <= req_addr_d;
            idx          <= idx_d;
            dup          <= dup_d;
            free_found   <= free_found_d;
            free_idx     <= free_idx_d;
            o_place_ack  <= ack_d;
            o_place_nack <= nack_d;
        end
    end

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            map            <= '0;
            vsync_q        <= 1'b1;
            o_data         <= 1'b0;
            o_explode      <= 1'b0;
            o_explode_addr <= '0;
            o_bomb_count   <= '0;
        end else begin
            vsync_q        <= i_vsync;
            o_data         <= map[i_addr];
            o_explode      <= serve_any;
            o_explode_addr <= serve_any ? slot_addr[serve_idx] : '0;
            if (serve_any) begin
                map[slot_addr[serve_idx]] <= 1'b0;
                o_bomb_count              <= o_bomb_count - 4'd1;
            end else if (commit) begin
                map[req_addr] <= 1'b1;
                o_bomb_count  <= o_bomb_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bomb_map.sv
module tb_bomb_map;

    localparam int NB = 4;
    localparam int FF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic [7:0] addr = '0;
    logic       req = 1'b0;
    logic [3:0] px = '0;
    logic [3:0] py = '0;
    logic       data, ack, nack, explode;
    logic [7:0] eaddr;
    logic [3:0] count;

    bomb_map #(.MAX_BOMBS(NB), .FUSE_FRAMES(FF)) dut (
        .i_pclk        (clk),
        .i_rst         (rst),
        .i_vsync       (vsync),
        .i_addr        (addr),
        .o_data        (data),
        .i_place_req   (req),
        .i_place_x     (px),
        .i_place_y     (py),
        .o_place_ack   (ack),
        .o_place_nack  (nack),
        .o_explode     (explode),
        .o_explode_addr(eaddr),
        .o_bomb_count  (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed explosions
    logic [7:0] got_addr[$];
    int         got_cyc[$];

    always @(negedge clk) begin
        if (!rst && explode) begin
            got_addr.push_back(eaddr);
            got_cyc.push_back(cyc);
        end
    end

    // Reference model: slot table of live bombs with remaining frames
    bit         m_valid[NB];
    logic [7:0] m_addr[NB];
    int         m_left[NB];
    logic [7:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 0;
            m_addr[i]  = '0;
            m_left[i]  = 0;
        end
    endfunction

    function automatic bit model_has(input logic [7:0] c);
        for (int i = 0; i < NB; i++)
            if (m_valid[i] && m_addr[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_live();
        int n = 0;
        for (int i = 0; i < NB; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic bit model_place(input logic [7:0] c);
        if (model_has(c)) return 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (!m_valid[i]) begin
                m_valid[i] = 1;
                m_addr[i]  = c;
                m_left[i]  = FF;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < NB; i++) begin
            if (m_valid[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    exp_q.push_back(m_addr[i]);
                    m_valid[i] = 0;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [7:0] c);
        addr = c;
        @(negedge clk);
        check("lookup", 32'(data), 32'(model_has(c)));
    endtask

    task automatic place(input logic [7:0] c);
        int n;
        bit exp;
        px  = c[3:0];
        py  = c[7:4];
        req = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack || nack) && n < 60);
        exp = model_place(c);
        check("place_timeout", 32'(n < 60), 32'd1);
        check("place_latency", 32'(n), 32'd6);
        check("place_ack", 32'(ack), 32'(exp));
        check("place_nack", 32'(nack), 32'(!exp));
        req = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ack || nack) && n < 10);
        check("place_release", 32'({ack, nack}), 32'd0);
        check("place_count", 32'(count), 32'(model_live()));
    endtask

    task automatic expect_explosions(input bit consecutive);
        repeat (NB + 4) @(negedge clk);
        check("explode_n", 32'(got_addr.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_addr.size()) begin
                check("explode_addr", 32'(got_addr[i]), 32'(exp_q[i]));
                if (consecutive && i > 0)
                    check("explode_gap", 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
            end
        end
        check("explode_count", 32'(count), 32'(model_live()));
        got_addr.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic frame_tick();
        vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        model_tick();
        expect_explosions(1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int ack_cyc;
        logic [7:0] c;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({data, ack, nack, explode, eaddr, count}), 32'd0);
        rst = 1'b0;

        // Lookup sweep on an empty map
        for (int a = 0; a <= 256; a++) begin
            if (a > 0) check("sweep", 32'(data), 32'd0);
            if (a < 256) addr = 8'(a);
            @(negedge clk);
        end
        check("idle_outputs", 32'({ack, nack, explode, count}), 32'd0);

        // First placement and its lookup visibility
        place(8'h23);
        lookup(8'h23);
        lookup(8'h24);
        // Duplicate
        place(8'h23);
        // Single bomb expiry
        frame_tick();
        frame_tick();
        frame_tick();
        lookup(8'h23);

        // Fill all slots, then overflow
        place(8'h23);
        place(8'h50);
        place(8'h0F);
        place(8'hFF);
        place(8'h77);
        lookup(8'hFF);
        lookup(8'h77);
        frame_tick();
        frame_tick();
        frame_tick();
        lookup(8'h50);

        // Two bombs expiring together with a placement raised on the tick
        place(8'h11);
        place(8'h45);
        frame_tick();
        frame_tick();
        px    = 4'hA;
        py    = 4'h3;
        req   = 1'b1;
        vsync = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack || nack) && n < 60);
        ack_cyc = cyc;
        model_tick();
        check("window_ack", 32'(ack), 32'(model_place(8'h3A)));
        check("window_after_serves", 32'(got_cyc.size() == 2 && ack_cyc > got_cyc[1]), 32'd1);
        req   = 1'b0;
        vsync = 1'b0;
        expect_explosions(1'b1);
        check("window_release", 32'({ack, nack}), 32'd0);
        lookup(8'h3A);
        lookup(8'h11);

        // Randomised traffic over a small cell set to provoke duplicates
        for (int it = 0; it < 80; it++) begin
            c = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: place(c);
                5, 6:          frame_tick();
                default:       lookup(c);
            endcase
        end
        repeat (FF) frame_tick();
        check("drain_count", 32'(count), 32'd0);

        // Async reset while holding ack in the response phase
        px  = 4'h9;
        py  = 4'h6;
        req = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack || nack) && n < 60);
        check("pre_rst_ack", 32'(ack), 32'(model_place(8'h69)));
        addr = 8'h69;
        #2 rst = 1'b1;
        #1 check("rst_async", 32'({ack, nack, count}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("rst_map_cleared", 32'(data), 32'd0);
        end while (!(ack || nack) && n < 60);
        check("rst_rereq_latency", 32'(n), 32'd6);
        check("rst_rereq_ack", 32'(ack), 32'(model_place(8'h69)));
        req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rereq_release", 32'({ack, nack}), 32'd0);
        lookup(8'h69);
        check("final_count", 32'(count), 32'(model_live()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
